// File: rtl/child_fifo_if.sv
// Handshake bundle between a producer/consumer and child_fifo.
// The master drives writes, reads and flush; the FIFO (slave) returns data and status.
interface child_fifo_if #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             w_enable;
    logic             r_enable;
    logic             flush;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, w_enable, r_enable, flush,
        input  out, out_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  in, w_enable, r_enable, flush,
        output out, out_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/child_fifo.sv
// Circular FIFO of DEPTH entries (any DEPTH in 2..255) holding {mut_child1, mut_child2} pairs,
// with registered read data, occupancy count and sticky overflow/underflow flags.
module child_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          reset,
    child_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] out_p1;
    logic             vld_p1;
    logic             ovf;
    logic             udf;
    logic             full_c;
    logic             empty_c;
    logic             wr_ok;
    logic             rd_ok;

    // Explicit compare-and-clear wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c  = (cnt == CNT_W'(DEPTH));
    assign empty_c = (cnt == '0);

    // A write into a full FIFO is only legal when the same-cycle read frees a slot.
    assign wr_ok = bus.w_enable && (!full_c || bus.r_enable);
    assign rd_ok = bus.r_enable && !empty_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            out_p1 <= '0;
            vld_p1 <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) begin
                out_p1 <= mem[rd_ptr];
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (wr_ok)
                wr_ptr <= ptr_next(wr_ptr);
            if (wr_ok && !rd_ok)
                cnt <= cnt + CNT_W'(1);
            else if (rd_ok && !wr_ok)
                cnt <= cnt - CNT_W'(1);
            if (bus.w_enable && full_c && !bus.r_enable)
                ovf <= 1'b1;
            if (bus.r_enable && empty_c)
                udf <= 1'b1;
        end
    end

    // Storage carries no reset; writes are gated so nothing lands while reset or flush is active.
    always_ff @(posedge clk) begin
        if (reset && !bus.flush && wr_ok)
            mem[wr_ptr] <= bus.in;
    end

    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;
endmodule

// File: tb/tb_child_fifo.sv
// Self-checking bench for child_fifo (DEPTH=3, WIDTH=16): directed vector table,
// hand-written wrap/flush/reset sequences, then random traffic against a queue model.
module tb_child_fifo;
    localparam int DEPTH = 3;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    child_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    child_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural reference: a queue plus the visible output registers.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_out;
    logic             m_vld;
    logic             m_ovf;
    logic             m_udf;

    typedef struct {
        logic        w;
        logic        r;
        logic        f;
        logic [15:0] d;
        logic [15:0] out;
        logic        vld;
        logic [1:0]  cnt;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t tbl[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model, sample just after the edge.
    task automatic step(input logic w, input logic r, input logic f, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        bus.w_enable = w;
        bus.r_enable = r;
        bus.flush    = f;
        bus.in       = d;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (f) begin
            mq.delete();
            m_vld = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_vld = r && !was_empty;
            if (w && was_full && !r) m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (m_vld) m_out = mq.pop_front();
            if (w && (!was_full || r)) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out"},       32'(bus.out),       32'(m_out));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
        check({tag, ".count"},     32'(bus.count),     32'(mq.size()));
        check({tag, ".full"},      32'(bus.full),      32'(mq.size() == DEPTH));
        check({tag, ".empty"},     32'(bus.empty),     32'(mq.size() == 0));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".out"},       32'(bus.out),       32'h0);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, ".count"},     32'(bus.count),     32'h0);
        check({tag, ".full"},      32'(bus.full),      32'h0);
        check({tag, ".empty"},     32'(bus.empty),     32'h1);
        check({tag, ".overflow"},  32'(bus.overflow),  32'h0);
        check({tag, ".underflow"}, 32'(bus.underflow), 32'h0);
    endtask

    initial begin
        //            w  r  f  d         out       vld cnt   full empty ovf udf
        tbl[0]  = '{1, 0, 0, 16'hA1B2, 16'h0000, 0, 2'd1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 16'hC3D4, 16'h0000, 0, 2'd2, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 16'hE5F6, 16'h0000, 0, 2'd3, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 16'h0000, 16'hA1B2, 1, 2'd2, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 16'h0000, 16'hC3D4, 1, 2'd1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 16'h0000, 16'hE5F6, 1, 2'd0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 16'h0000, 16'hE5F6, 0, 2'd0, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 16'h0001, 16'hE5F6, 0, 2'd1, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 16'h0002, 16'hE5F6, 0, 2'd2, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 16'h0003, 16'hE5F6, 0, 2'd3, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 16'h1111, 16'hE5F6, 0, 2'd3, 1, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 16'h0000, 16'h0001, 1, 2'd2, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 16'h0000, 16'h0002, 1, 2'd1, 0, 0, 1, 0};
        tbl[13] = '{0, 1, 0, 16'h0000, 16'h0003, 1, 2'd0, 0, 1, 1, 0};
        tbl[14] = '{0, 0, 1, 16'h0000, 16'h0003, 0, 2'd0, 0, 1, 0, 0};
        tbl[15] = '{1, 0, 0, 16'h0004, 16'h0003, 0, 2'd1, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 16'h0005, 16'h0003, 0, 2'd2, 0, 0, 0, 0};
        tbl[17] = '{1, 0, 0, 16'h0006, 16'h0003, 0, 2'd3, 1, 0, 0, 0};
        tbl[18] = '{1, 1, 0, 16'h2222, 16'h0004, 1, 2'd3, 1, 0, 0, 0};
        tbl[19] = '{0, 1, 0, 16'h0000, 16'h0005, 1, 2'd2, 0, 0, 0, 0};
        tbl[20] = '{0, 1, 0, 16'h0000, 16'h0006, 1, 2'd1, 0, 0, 0, 0};
        tbl[21] = '{0, 1, 0, 16'h0000, 16'h2222, 1, 2'd0, 0, 1, 0, 0};
        tbl[22] = '{1, 1, 0, 16'h3333, 16'h2222, 0, 2'd1, 0, 0, 0, 1};
        tbl[23] = '{0, 1, 0, 16'h0000, 16'h3333, 1, 2'd0, 0, 1, 0, 1};
        tbl[24] = '{1, 0, 0, 16'h0007, 16'h3333, 0, 2'd1, 0, 0, 0, 1};
        tbl[25] = '{1, 0, 0, 16'h0008, 16'h3333, 0, 2'd2, 0, 0, 0, 1};
        tbl[26] = '{1, 0, 1, 16'h9999, 16'h3333, 0, 2'd0, 0, 1, 0, 0};
        tbl[27] = '{0, 1, 0, 16'h0000, 16'h3333, 0, 2'd0, 0, 1, 0, 1};

        bus.in       = '0;
        bus.w_enable = 1'b0;
        bus.r_enable = 1'b0;
        bus.flush    = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 28; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].d);
            check({tag, ".out"},       32'(bus.out),       32'(tbl[i].out));
            check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(tbl[i].vld));
            check({tag, ".count"},     32'(bus.count),     32'(tbl[i].cnt));
            check({tag, ".full"},      32'(bus.full),      32'(tbl[i].full));
            check({tag, ".empty"},     32'(bus.empty),     32'(tbl[i].empty));
            check({tag, ".overflow"},  32'(bus.overflow),  32'(tbl[i].ovf));
            check({tag, ".underflow"}, 32'(bus.underflow), 32'(tbl[i].udf));
        end

        // Ten write/read pairs walk both pointers around the ring more than three times.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(i));
            check($sformatf("wrap%0d.count_w", i), 32'(bus.count), 32'd1);
            step(1'b0, 1'b1, 1'b0, 16'h0);
            check($sformatf("wrap%0d.out", i),       32'(bus.out),       32'(i));
            check($sformatf("wrap%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("wrap%0d.count_r", i),   32'(bus.count),     32'd0);
        end

        // Asynchronous reset dropped between edges with entries held.
        step(1'b1, 1'b0, 1'b0, 16'hAAAA);
        step(1'b1, 1'b0, 1'b0, 16'hBBBB);
        check_model("prereset");
        @(posedge clk);
        #2;
        bus.w_enable = 1'b1;
        bus.r_enable = 1'b1;
        bus.in       = 16'hCCCC;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        @(negedge clk);
        bus.w_enable = 1'b0;
        bus.r_enable = 1'b0;
        reset = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check_model("post_rst_read");

        for (int i = 0; i < 600; i++) begin
            logic w, r, f;
            if (i < 300) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            f = ($urandom_range(0, 39) == 0);
            step(w, r, f, 16'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
